simplez_seq: RTL and testbench
==============================

# simplez_seq

Complete microprogram-free sequencer for the SIMPLEZ processor. It decodes the opcode held in the instruction register and drives every microorder of the datapath (memory, RA, RI, CP, AC/ALU) for all eight instructions. It also inserts memory wait states and handles HALT and restart. It sits between the RI/Z flag and the datapath inside the simplez top level, replacing the partial inline sequencer.

## Interface
Parameters: none (SIMPLEZ instruction format fixed: CO = RI[11:9]).

Ports:
- clk  in  1  system clock; all state updates on the falling edge, the same as the datapath registers
- rstn  in  1  reset, asynchronous, active-low
- co  in  3  opcode RI[11:9]: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7
- zero  in  1  accumulator-is-zero flag, registered in the datapath
- mem_ready  in  1  memory/peripheral ready; 0 inserts a wait state
- run  in  1  restart request while halted (level)
- lec  out  1  memory read
- esc  out  1  memory write
- era  out  1  load RA from internal address bus
- eri  out  1  load RI from data bus
- incp  out  1  CP <= CP+1
- ecp  out  1  CP <= internal address bus
- ccp  out  1  CP <= 0
- scp  out  1  CP drives internal address bus
- sri  out  1  RI[8:0] drives internal address bus
- sac  out  1  AC drives data bus
- eac  out  1  load AC from ALU
- alu_op  out  2  00 pass busD, 01 AC+busD, 10 AC-1, 11 clear
- stop  out  1  processor halted
- state  out  3  debug: I0=0, I1=1, O0=2, O1=3, HLT=4

## Operation
- Inputs co and zero are sampled in I1 and O0. RI is stable after I0, because eri is asserted only in I0.
- Outputs are combinational from state, co, zero, mem_ready and run. Any microorder not listed below is 0, and alu_op defaults to 00.
- I0 (fetch): lec=1.
  - mem_ready=0: hold in I0; eri and incp stay 0.
  - mem_ready=1: eri=1, incp=1; next state I1.
- I1 (decode), by opcode:
  - ST, LD, ADD: sri=1, era=1; next O0.
  - BR: sri=1, era=1, ecp=1; next I0.
  - BZ with zero=1: same as BR. BZ with zero=0: scp=1, era=1; next I0.
  - CLR: eac=1, alu_op=11, scp=1, era=1; next I0.
  - DEC: eac=1, alu_op=10, scp=1, era=1; next I0.
  - HALT: stop=1; next HLT.
- O0 (operand access):
  - ST: sac=1 while in O0; esc=1 only when mem_ready=1.
  - LD and ADD: lec=1 while in O0. When mem_ready=1, also eac=1 with alu_op=00 (LD) or 01 (ADD).
  - mem_ready=0: hold in O0 with no eac and no esc. mem_ready=1: next O1.
- O1 (end of cycle): scp=1, era=1; next I0.
- HLT: stop=1.
  - run=0: stay in HLT.
  - run=1: ccp=1; next O1. O1 then loads RA with the cleared CP, so execution restarts at address 0.
- Undefined state codes 5–7: all microorders 0; next I0.

## Timing
- Reset: while rstn=0, state=I0 (asynchronous) and every output is forced to 0, including stop. After release, the first falling edge with mem_ready=1 completes the fetch from RA.
- Cycle counts with mem_ready held at 1:
  - ST, LD, ADD: 4 cycles (I0, I1, O0, O1).
  - BR, BZ, CLR, DEC: 2 cycles (I0, I1).
  - HALT: 2 cycles to reach HLT.
- Each cycle with mem_ready=0 in I0 or O0 adds exactly one cycle. mem_ready is ignored in every other state.
- In any single cycle, at most one of incp, ecp, ccp is 1, and at most one of scp, sri is 1.
- run is ignored outside HLT. run=1 held continuously in HLT restarts once; the processor then runs normally.
- Reset asserted mid-instruction returns to I0 immediately, even if esc or eac were active.

## Test plan
- Reset with mem_ready=1 and co=1 (LD) → state sequence 0,1,2,3,0. The I0 cycle shows lec, eri, incp=1. The O0 cycle shows lec=1, eac=1, alu_op=00. The O1 cycle shows scp=1, era=1.
- co=4 (BZ) with zero=1, then again with zero=0 → zero=1 gives I1 outputs sri, era, ecp=1. zero=0 gives I1 outputs scp, era=1 with ecp=0. Both return to I0 after 2 cycles.
- co=0 (ST) with mem_ready held 0 for 3 cycles in O0 → state stays 2 for 4 cycles. sac=1 throughout. esc=1 only in the final cycle, then O1.
- co=7 (HALT) → state 4 with stop=1 for 10 cycles while run=0. run=1 for one cycle → ccp=1 in that cycle, then state 3 then 0, with stop=0.
- co=6 (DEC), then co=5 (CLR) → I1 outputs eac=1 with alu_op=10 and alu_op=11 respectively. Each instruction takes 2 cycles.
- Assert rstn=0 in the middle of O0 for ST → all outputs drop to 0 asynchronously, without waiting for a clock edge. After release, state=0.

Source files
------------

// File: rtl/simplez_seq.sv
// simplez_seq -- hardwired (microprogram-free) sequencer for the SIMPLEZ CPU.
//
// Decodes the opcode held in RI and drives every datapath microorder. Memory
// wait states are inserted in the fetch (I0) and operand (O0) phases. HALT
// parks the machine in HLT until a restart request arrives.
// State updates on the falling clock edge, like the datapath registers.
//
// Ports
//   clk        system clock (state changes on the falling edge)
//   rstn       asynchronous active-low reset
//   co[2:0]    opcode RI[11:9]: ST LD ADD BR BZ CLR DEC HALT
//   zero       accumulator-is-zero flag
//   mem_ready  memory ready; 0 stretches I0/O0 by one cycle
//   run        restart request while halted (level)
//   lec/esc    memory read / write
//   era/eri    load RA / load RI
//   incp/ecp/ccp  CP+1 / CP<=bus / CP<=0
//   scp/sri    CP / RI[8:0] drive the internal address bus
//   sac/eac    AC drives the data bus / load AC from the ALU
//   alu_op     00 pass, 01 add, 10 decrement, 11 clear
//   stop       processor halted
//   state      debug view of the sequencer state
module simplez_seq (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] co,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       run,
  output logic       lec,
  output logic       esc,
  output logic       era,
  output logic       eri,
  output logic       incp,
  output logic       ecp,
  output logic       ccp,
  output logic       scp,
  output logic       sri,
  output logic       sac,
  output logic       eac,
  output logic [1:0] alu_op,
  output logic       stop,
  output logic [2:0] state
);

  localparam logic [2:0] S_I0  = 3'd0;
  localparam logic [2:0] S_I1  = 3'd1;
  localparam logic [2:0] S_O0  = 3'd2;
  localparam logic [2:0] S_O1  = 3'd3;
  localparam logic [2:0] S_HLT = 3'd4;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_DEC  = 2'b10;
  localparam logic [1:0] ALU_CLR  = 2'b11;

  logic [2:0] r_state;
  logic [2:0] w_next;

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_I0;
    else       r_state <= w_next;
  end

  assign state = r_state;

  // Next-state logic.
  always_comb begin
    w_next = S_I0;
    case (r_state)
      S_I0:  w_next = mem_ready ? S_I1 : S_I0;
      S_I1: begin
        case (co)
          OP_ST, OP_LD, OP_ADD: w_next = S_O0;
          OP_HALT:              w_next = S_HLT;
          default:              w_next = S_I0;
        endcase
      end
      S_O0:  w_next = mem_ready ? S_O1 : S_O0;
      S_O1:  w_next = S_I0;
      S_HLT: w_next = run ? S_O1 : S_HLT;
      default: w_next = S_I0;
    endcase
  end

  // Microorder decode. Everything is held low while rstn is asserted, so the
  // outputs drop without waiting for a clock edge even though I0 would
  // otherwise assert lec.
  always_comb begin
    lec    = 1'b0;
    esc    = 1'b0;
    era    = 1'b0;
    eri    = 1'b0;
    incp   = 1'b0;
    ecp    = 1'b0;
    ccp    = 1'b0;
    scp    = 1'b0;
    sri    = 1'b0;
    sac    = 1'b0;
    eac    = 1'b0;
    alu_op = ALU_PASS;
    stop   = 1'b0;
    if (rstn) begin
      case (r_state)
        S_I0: begin
          lec = 1'b1;
          if (mem_ready) begin
            eri  = 1'b1;
            incp = 1'b1;
          end
        end
        S_I1: begin
          case (co)
            OP_ST, OP_LD, OP_ADD: begin
              sri = 1'b1;
              era = 1'b1;
            end
            OP_BR: begin
              sri = 1'b1;
              era = 1'b1;
              ecp = 1'b1;
            end
            OP_BZ: begin
              era = 1'b1;
              if (zero) begin
                sri = 1'b1;
                ecp = 1'b1;
              end else begin
                scp = 1'b1;
              end
            end
            OP_CLR: begin
              eac    = 1'b1;
              alu_op = ALU_CLR;
              scp    = 1'b1;
              era    = 1'b1;
            end
            OP_DEC: begin
              eac    = 1'b1;
              alu_op = ALU_DEC;
              scp    = 1'b1;
              era    = 1'b1;
            end
            default: stop = 1'b1;  // HALT
          endcase
        end
        S_O0: begin
          case (co)
            OP_ST: begin
              sac = 1'b1;
              esc = mem_ready;
            end
            OP_LD: begin
              lec = 1'b1;
              eac = mem_ready;
            end
            OP_ADD: begin
              lec = 1'b1;
              eac = mem_ready;
              if (mem_ready) alu_op = ALU_ADD;
            end
            default: ;
          endcase
        end
        S_O1: begin
          scp = 1'b1;
          era = 1'b1;
        end
        S_HLT: begin
          stop = 1'b1;
          ccp  = run;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_seq.sv
module tb_simplez_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] co;
  logic       zero;
  logic       mem_ready;
  logic       run;
  logic       lec, esc, era, eri, incp, ecp, ccp, scp, sri, sac, eac, stop;
  logic [1:0] alu_op;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int ph;  // model phase: 0 fetch, 1 decode, 2 operand, 3 end, 4 halted

  simplez_seq dut (
    .clk(clk), .rstn(rstn), .co(co), .zero(zero), .mem_ready(mem_ready),
    .run(run), .lec(lec), .esc(esc), .era(era), .eri(eri), .incp(incp),
    .ecp(ecp), .ccp(ccp), .scp(scp), .sri(sri), .sac(sac), .eac(eac),
    .alu_op(alu_op), .stop(stop), .state(state)
  );

  always #5 clk = ~clk;

  // Output vector: {lec,esc,era,eri,incp,ecp,ccp,scp,sri,sac,eac,alu_op,stop}
  localparam logic [13:0] LEC  = 14'b10000000000000;
  localparam logic [13:0] ESC  = 14'b01000000000000;
  localparam logic [13:0] ERA  = 14'b00100000000000;
  localparam logic [13:0] ERI  = 14'b00010000000000;
  localparam logic [13:0] INCP = 14'b00001000000000;
  localparam logic [13:0] ECP  = 14'b00000100000000;
  localparam logic [13:0] CCP  = 14'b00000010000000;
  localparam logic [13:0] SCP  = 14'b00000001000000;
  localparam logic [13:0] SRI  = 14'b00000000100000;
  localparam logic [13:0] SAC  = 14'b00000000010000;
  localparam logic [13:0] EAC  = 14'b00000000001000;
  localparam logic [13:0] ALU1 = 14'b00000000000010;
  localparam logic [13:0] ALU2 = 14'b00000000000100;
  localparam logic [13:0] ALU3 = 14'b00000000000110;
  localparam logic [13:0] STP  = 14'b00000000000001;

  // Per-opcode decode table: microorders in the decode cycle and the
  // phase that follows it. BZ's entry is its taken form.
  logic [13:0] dec_mo  [8];
  int          dec_nxt [8];
  initial begin
    dec_mo[0] = SRI | ERA;             dec_nxt[0] = 2;
    dec_mo[1] = SRI | ERA;             dec_nxt[1] = 2;
    dec_mo[2] = SRI | ERA;             dec_nxt[2] = 2;
    dec_mo[3] = SRI | ERA | ECP;       dec_nxt[3] = 0;
    dec_mo[4] = SRI | ERA | ECP;       dec_nxt[4] = 0;
    dec_mo[5] = EAC | ALU3 | SCP | ERA; dec_nxt[5] = 0;
    dec_mo[6] = EAC | ALU2 | SCP | ERA; dec_nxt[6] = 0;
    dec_mo[7] = STP;                   dec_nxt[7] = 4;
  end

  function automatic logic [13:0] model_out(int p, logic [2:0] c, logic z,
                                            logic rdy, logic rn);
    logic [13:0] o;
    o = '0;
    case (p)
      0: o = rdy ? (LEC | ERI | INCP) : LEC;
      1: o = (c == 3'd4 && !z) ? (SCP | ERA) : dec_mo[c];
      2: begin
        if (c == 3'd0)      o = rdy ? (SAC | ESC) : SAC;
        else if (c == 3'd1) o = rdy ? (LEC | EAC) : LEC;
        else if (c == 3'd2) o = rdy ? (LEC | EAC | ALU1) : LEC;
      end
      3: o = SCP | ERA;
      4: o = rn ? (STP | CCP) : STP;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic int model_next(int p, logic [2:0] c, logic rdy, logic rn);
    case (p)
      0: return rdy ? 1 : 0;
      1: return dec_nxt[c];
      2: return rdy ? 3 : 2;
      4: return rn ? 3 : 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [13:0] dut_vec();
    return {lec, esc, era, eri, incp, ecp, ccp, scp, sri, sac, eac, alu_op, stop};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model on the
  // active (falling) edge. exp_state >= 0 additionally checks a fixed state.
  task automatic cyc(input int exp_state);
    logic [13:0] v;
    @(posedge clk);
    #1;
    v = dut_vec();
    check("outputs", {2'b0, v}, {2'b0, model_out(ph, co, zero, mem_ready, run)});
    check("state_model", {13'b0, state}, ph[15:0]);
    if (exp_state >= 0) check("state_seq", {13'b0, state}, exp_state[15:0]);
    check("one_hot_cp", {15'b0, (incp + ecp + ccp) > 2'd1}, 16'd0);
    check("one_hot_bus", {15'b0, scp & sri}, 16'd0);
    @(negedge clk);
    ph = model_next(ph, co, mem_ready, run);
    #1;
  endtask

  initial begin
    rstn = 1'b0; co = 3'd1; zero = 1'b0; mem_ready = 1'b1; run = 1'b0;
    ph = 0;
    #2;
    check("reset_outputs", {2'b0, dut_vec()}, 16'd0);
    check("reset_state", {13'b0, state}, 16'd0);
    @(negedge clk); #1;
    rstn = 1'b1;

    // LD: 0,1,2,3,0
    cyc(0); cyc(1); cyc(2); cyc(3);
    // BZ taken then not taken
    co = 3'd4; zero = 1'b1;
    cyc(0); cyc(1);
    zero = 1'b0;
    cyc(0); cyc(1);
    // ST with three wait states in O0
    co = 3'd0;
    cyc(0); cyc(1);
    mem_ready = 1'b0;
    cyc(2); cyc(2); cyc(2);
    mem_ready = 1'b1;
    cyc(2); cyc(3);
    // HALT, park ten cycles, then one-cycle run pulse
    co = 3'd7;
    cyc(0); cyc(1);
    for (int i = 0; i < 10; i++) cyc(4);
    run = 1'b1;
    cyc(4);
    run = 1'b0;
    cyc(3);
    // DEC then CLR; run held high outside HLT is ignored
    co = 3'd6; run = 1'b1;
    cyc(0); cyc(1);
    co = 3'd5;
    cyc(0); cyc(1);
    run = 1'b0;
    // Fetch wait state
    mem_ready = 1'b0;
    cyc(0);
    mem_ready = 1'b1;
    cyc(0);
    // Reset in the middle of an ST operand phase
    co = 3'd0;
    cyc(1);
    mem_ready = 1'b0;
    cyc(2);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("async_rst_outputs", {2'b0, dut_vec()}, 16'd0);
    check("async_rst_state", {13'b0, state}, 16'd0);
    @(negedge clk); #1;
    rstn = 1'b1; ph = 0; mem_ready = 1'b1;
    cyc(0);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      co        = 3'($urandom_range(0, 7));
      zero      = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      run       = ($urandom_range(0, 5) == 0);
      cyc(-1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
